// File: rtl/store_pack_buffer_pkg.sv
// Shared definitions for the store pack buffer: store op codes, byte-enable
// patterns and the FIFO entry layout.
package store_pack_buffer_pkg;

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane placement for sw/sh/sb: replicates sub-word data across
// the word and selects the byte lanes, flagging illegal or misaligned stores.
module store_lane_pack
    import store_pack_buffer_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byteen_o,
    output logic [31:0] data_o,
    output logic        reject_o
);

    always_comb begin
        byteen_o = '0;
        data_o   = '0;
        reject_o = 1'b0;
        case (op_i)
            OP_SW: begin
                byteen_o = BE_WORD;
                data_o   = wdata_i;
                reject_o = (addr_lo_i != 2'b00);
            end
            OP_SH: begin
                byteen_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                data_o   = {2{wdata_i[15:0]}};
                reject_o = addr_lo_i[0];
            end
            OP_SB: begin
                byteen_o = 4'b0001 << addr_lo_i;
                data_o   = {4{wdata_i[7:0]}};
            end
            default: begin
                reject_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_pack_buffer.sv
// Store request queue toward the data-memory write port: packs sub-word stores
// onto byte lanes, queues them in a small FIFO and reports rejected stores.
module store_pack_buffer
    import store_pack_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_byteen,
    output logic [31:0]      mem_wdata,
    output logic             exc_valid,
    output logic [31:0]      exc_addr,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exc_valid_q, exc_valid_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    entry_t mem_q [DEPTH];
    entry_t last_q;
    entry_t head;
    entry_t new_entry;

    logic [3:0]  pk_byteen;
    logic [31:0] pk_data;
    logic        pk_reject;
    logic        accept;
    logic        push;
    logic        pop;

    store_lane_pack u_lane_pack (
        .op_i      (req_op),
        .addr_lo_i (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .byteen_o  (pk_byteen),
        .data_o    (pk_data),
        .reject_o  (pk_reject)
    );

    // Handshake: a request is consumed when req_valid && req_ready at a rising
    // edge; the head entry is consumed when mem_valid && mem_ready. req_ready
    // depends only on occupancy, never on mem_ready.
    assign req_ready = (count_q < CNT_W'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !pk_reject && !flush;
    assign pop       = mem_valid && mem_ready && !flush;

    assign new_entry = '{addr: {req_addr[31:2], 2'b00}, byteen: pk_byteen, wdata: pk_data};

    // Once the queue drains the port keeps showing the last head it presented.
    assign head       = mem_valid ? mem_q[rd_ptr_q] : last_q;
    assign mem_addr   = head.addr;
    assign mem_byteen = head.byteen;
    assign mem_wdata  = head.wdata;
    assign exc_valid  = exc_valid_q;
    assign exc_addr   = exc_addr_q;
    assign count      = count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        exc_valid_d = 1'b0;
        exc_addr_d  = exc_addr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (accept && pk_reject) begin
                exc_valid_d = 1'b1;
                exc_addr_d  = req_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
            last_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exc_valid_q <= exc_valid_d;
            exc_addr_q  <= exc_addr_d;
            if (mem_valid) begin
                last_q <= head;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

endmodule

// File: tb/tb_store_pack_buffer.sv
// Bench for store_pack_buffer: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_store_pack_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_byteen;
  logic [31:0]      mem_wdata;
  logic             exc_valid;
  logic [31:0]      exc_addr;
  logic [CNT_W-1:0] count;

  store_pack_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .exc_valid  (exc_valid),
    .exc_addr   (exc_addr),
    .count      (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: each entry is {word addr, byteen, data}
  logic [67:0] exp_q[$];
  logic        exp_exc;
  logic [31:0] exp_exc_addr;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit is_illegal(input logic [1:0] op, input logic [31:0] addr);
    int offs;
    offs = int'(addr % 4);
    return (op == 2'd3) || (op == 2'd0 && offs != 0) || (op == 2'd1 && (offs % 2) != 0);
  endfunction

  function automatic logic [67:0] pack_model(input logic [1:0] op, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    int          offs;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] waddr;
    offs  = int'(addr % 4);
    waddr = addr - 32'(offs);
    be    = 4'hF;
    d     = wdata;
    if (op == 2'd1) begin
      be = (offs >= 2) ? 4'hC : 4'h3;
      d  = {wdata[15:0], wdata[15:0]};
    end else if (op == 2'd2) begin
      be = 4'(1 << offs);
      d  = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
    end
    return {waddr, be, d};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_exc      = 1'b0;
    exp_exc_addr = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit ready;
    ready = (exp_q.size() < DEPTH);
    if (flush) begin
      exp_q.delete();
      exp_exc = 1'b0;
    end else begin
      exp_exc = 1'b0;
      if (exp_q.size() != 0 && mem_ready) void'(exp_q.pop_front());
      if (req_valid && ready) begin
        if (is_illegal(req_op, req_addr)) begin
          exp_exc      = 1'b1;
          exp_exc_addr = req_addr;
        end else begin
          exp_q.push_back(pack_model(req_op, req_addr, req_wdata));
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [67:0] h;
    check("count", 32'(count), 32'(exp_q.size()));
    check("mem_valid", 32'(mem_valid), 32'(exp_q.size() != 0));
    check("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
    check("exc_valid", 32'(exc_valid), 32'(exp_exc));
    check("exc_addr", exc_addr, exp_exc_addr);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("mem_addr", mem_addr, h[67:36]);
      check("mem_byteen", 32'(mem_byteen), 32'(h[35:32]));
      check("mem_wdata", mem_wdata, h[31:0]);
    end
  endtask

  // driver: called at a negedge, applies inputs for one cycle, checks after it
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic mr, input logic fl);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    mem_ready = mr;
    flush     = fl;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 2'd0, 32'h0, 32'h0, mr, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    model_reset();
    #12;
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_exc_valid", 32'(exc_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs();

    // 1: sb to 0x1003
    step(1'b1, 2'd2, 32'h1003, 32'h0000_00A5, 1'b1, 1'b0);
    check("t1_addr", mem_addr, 32'h1000);
    check("t1_be", 32'(mem_byteen), 32'h8);
    check("t1_data", mem_wdata, 32'hA5A5_A5A5);
    idle(1'b1);
    check("t1_count", 32'(count), 32'h0);

    // 2: sh to 0x2002 then 0x2000
    step(1'b1, 2'd1, 32'h2002, 32'h1234_BEEF, 1'b0, 1'b0);
    check("t2_be_hi", 32'(mem_byteen), 32'hC);
    step(1'b1, 2'd1, 32'h2000, 32'h1234_BEEF, 1'b1, 1'b0);
    check("t2_data0", mem_wdata, 32'hBEEF_BEEF);
    idle(1'b1);
    check("t2_be_lo", 32'(mem_byteen), 32'h3);
    idle(1'b1);

    // 3: back-pressure with three sw
    step(1'b1, 2'd0, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h14, 32'h2222_0014, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h18, 32'h3333_0018, 1'b0, 1'b0);
    check("t3_ready_full", 32'(req_ready), 32'h0);
    check("t3_stall_addr", mem_addr, 32'h10);
    step(1'b1, 2'd0, 32'h18, 32'h3333_0018, 1'b1, 1'b0);
    step(1'b1, 2'd0, 32'h18, 32'h3333_0018, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 4: rejections
    step(1'b1, 2'd0, 32'h3001, 32'h0, 1'b1, 1'b0);
    check("t4_exc0", exc_addr, 32'h3001);
    step(1'b1, 2'd3, 32'h4000, 32'h0, 1'b1, 1'b0);
    check("t4_exc1", exc_addr, 32'h4000);
    idle(1'b1);

    // 5: flush with a concurrent push
    step(1'b1, 2'd0, 32'h40, 32'hAAAA_0040, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h44, 32'hBBBB_0044, 1'b0, 1'b0);
    step(1'b1, 2'd2, 32'h50, 32'h0000_0077, 1'b1, 1'b1);
    check("t5_count", 32'(count), 32'h0);
    idle(1'b1);

    // 6: streaming push+pop at count 1, then reset mid-stream
    step(1'b1, 2'd0, 32'h100, 32'hC000_0000, 1'b1, 1'b0);
    for (int i = 1; i <= 2 * DEPTH + 1; i++)
      step(1'b1, 2'd0, 32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", 32'(mem_valid), 32'h0);
    check("t6_rst_count", 32'(count), 32'h0);
    check("t6_rst_addr", mem_addr, 32'h0);
    check("t6_rst_be", 32'(mem_byteen), 32'h0);
    check("t6_rst_data", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3))};
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
